// File: rtl/lsu_ctrl_pkg.sv
// Shared op codes, FSM state encoding and small decode helpers for the load/store unit.
package lsu_ctrl_pkg;

   localparam logic [3:0] MEM_NOP = 4'd0;
   localparam logic [3:0] MEM_LB  = 4'd1;
   localparam logic [3:0] MEM_LH  = 4'd2;
   localparam logic [3:0] MEM_LW  = 4'd3;
   localparam logic [3:0] MEM_LBU = 4'd4;
   localparam logic [3:0] MEM_LHU = 4'd5;
   localparam logic [3:0] MEM_SB  = 4'd6;
   localparam logic [3:0] MEM_SH  = 4'd7;
   localparam logic [3:0] MEM_SW  = 4'd8;

   localparam logic [31:0] ZERO     = 32'h0000_0000;
   localparam logic [4:0]  ZERO_REG = 5'd0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_DONE  = 3'd5
   } lsu_state_e;

   // Codes 9..15 fall outside LB..SW and therefore behave as MEM_NOP.
   function automatic logic op_valid(input logic [3:0] op);
      return (op >= MEM_LB) && (op <= MEM_SW);
   endfunction

   function automatic logic op_is_load(input logic [3:0] op);
      return (op >= MEM_LB) && (op <= MEM_LHU);
   endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Size/mask/split computation, store-lane positioning and load extraction for one access.
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  offset,
   input  logic [31:0] sdata,
   input  logic [63:0] rbuf,
   output logic [7:0]  mask,
   output logic [63:0] wdata,
   output logic        split,
   output logic [31:0] ldata
);

   logic [7:0]  base;
   logic [31:0] shifted;

   always_comb begin
      base = 8'h0F;
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: base = 8'h01;
         MEM_LH, MEM_LHU, MEM_SH: base = 8'h03;
         default:                 base = 8'h0F;
      endcase
   end

   assign mask    = base << offset;
   assign split   = |mask[7:4];
   assign wdata   = {32'h0, sdata} << {offset, 3'b000};
   assign shifted = 32'(rbuf >> {offset, 3'b000});

   always_comb begin
      ldata = ZERO;
      case (op)
         MEM_LB:  ldata = {{24{shifted[7]}}, shifted[7:0]};
         MEM_LBU: ldata = {24'h0, shifted[7:0]};
         MEM_LH:  ldata = {{16{shifted[15]}}, shifted[15:0]};
         MEM_LHU: ldata = {16'h0, shifted[15:0]};
         MEM_LW:  ldata = shifted;
         default: ldata = ZERO;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns one pipeline memory op into one or two aligned word transactions.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a valid op; latches it and the split flag
// REQ0     | first-word request on the bus, held until grant
// WAIT0    | waiting for first response, captures low word
// REQ1     | second-word request (split only), held until grant
// WAIT1    | waiting for second response, captures high word
// DONE     | load writeback strobe; pipeline advances, back to IDLE
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [3:0]            mem_op_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic [4:0]            reg_waddr_i,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [3:0]            bus_be_o,
   output logic [DATA_WIDTH-1:0] bus_wdata_o,
   input  logic                  bus_gnt_i,
   input  logic                  bus_rvalid_i,
   input  logic [DATA_WIDTH-1:0] bus_rdata_i,
   output logic                  reg_we_o,
   output logic [4:0]            reg_waddr_o,
   output logic [DATA_WIDTH-1:0] reg_wdata_o,
   output logic                  stallreq_o
);

   lsu_state_e state, state_nxt;

   logic [3:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           data_q;
   logic [4:0]            waddr_q;
   logic                  split_q;
   logic [31:0]           lo_q, hi_q, lo_nxt, hi_nxt;

   logic                  in_idle;
   logic [3:0]            a_op;
   logic [ADDR_WIDTH-1:0] base_addr, word0, word1;
   logic [31:0]           a_sdata, a_ldata;
   logic [7:0]            a_mask;
   logic [63:0]           a_wdata;
   logic                  a_split;
   logic                  accept;

   // In IDLE the request fields for REQ0 are built from the live inputs; afterwards from the latch.
   assign in_idle   = (state == ST_IDLE);
   assign a_op      = in_idle ? mem_op_i   : op_q;
   assign base_addr = in_idle ? mem_addr_i : addr_q;
   assign a_sdata   = in_idle ? mem_data_i : data_q;
   assign word0     = {base_addr[ADDR_WIDTH-1:2], 2'b00};
   assign word1     = word0 + ADDR_WIDTH'(4);
   assign accept    = in_idle && (state_nxt == ST_REQ0);

   lsu_align u_align (
      .op     (a_op),
      .offset (base_addr[1:0]),
      .sdata  (a_sdata),
      .rbuf   ({hi_nxt, lo_nxt}),
      .mask   (a_mask),
      .wdata  (a_wdata),
      .split  (a_split),
      .ldata  (a_ldata)
   );

   always_comb begin
      state_nxt = state;
      lo_nxt    = lo_q;
      hi_nxt    = hi_q;
      case (state)
         ST_IDLE:  if (op_valid(mem_op_i)) state_nxt = ST_REQ0;
         ST_REQ0:  if (bus_gnt_i) state_nxt = ST_WAIT0;
         ST_WAIT0: if (bus_rvalid_i) begin
                      lo_nxt    = bus_rdata_i;
                      state_nxt = split_q ? ST_REQ1 : ST_DONE;
                   end
         ST_REQ1:  if (bus_gnt_i) state_nxt = ST_WAIT1;
         ST_WAIT1: if (bus_rvalid_i) begin
                      hi_nxt    = bus_rdata_i;
                      state_nxt = ST_DONE;
                   end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign stallreq_o = in_idle ? op_valid(mem_op_i) : (state != ST_DONE);

   // Outputs are registered from the next state so they line up with the state being entered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         op_q        <= MEM_NOP;
         addr_q      <= '0;
         data_q      <= ZERO;
         waddr_q     <= ZERO_REG;
         split_q     <= 1'b0;
         lo_q        <= ZERO;
         hi_q        <= ZERO;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= 4'h0;
         bus_wdata_o <= ZERO;
         reg_we_o    <= 1'b0;
         reg_waddr_o <= ZERO_REG;
         reg_wdata_o <= ZERO;
      end else begin
         state     <= state_nxt;
         lo_q      <= lo_nxt;
         hi_q      <= hi_nxt;
         bus_req_o <= (state_nxt == ST_REQ0) || (state_nxt == ST_REQ1);
         reg_we_o  <= (state_nxt == ST_DONE) && op_is_load(op_q);
         if (accept) begin
            op_q        <= mem_op_i;
            addr_q      <= mem_addr_i;
            data_q      <= mem_data_i;
            waddr_q     <= reg_waddr_i;
            split_q     <= a_split;
            bus_we_o    <= !op_is_load(mem_op_i);
            bus_addr_o  <= word0;
            bus_be_o    <= a_mask[3:0];
            bus_wdata_o <= a_wdata[31:0];
         end
         if ((state == ST_WAIT0) && (state_nxt == ST_REQ1)) begin
            bus_addr_o  <= word1;
            bus_be_o    <= a_mask[7:4];
            bus_wdata_o <= a_wdata[63:32];
         end
         if ((state_nxt == ST_DONE) && op_is_load(op_q)) begin
            reg_waddr_o <= waddr_q;
            reg_wdata_o <= a_ldata;
         end
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected bus transactions and writebacks are queued at issue time.
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   logic        clk_i, rst_i;
   logic [3:0]  mem_op_i;
   logic [31:0] mem_addr_i, mem_data_i;
   logic [4:0]  reg_waddr_i;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_gnt_i, bus_rvalid_i;
   logic [31:0] bus_rdata_i;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
   logic        stallreq_o;

   lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
      .mem_data_i(mem_data_i), .reg_waddr_i(reg_waddr_i), .bus_req_o(bus_req_o),
      .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
      .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
      .bus_rdata_i(bus_rdata_i), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
      .reg_wdata_o(reg_wdata_o), .stallreq_o(stallreq_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } tx_t;
   typedef struct { logic [4:0] waddr; logic [31:0] wdata; } wb_t;

   tx_t tx_q[$];
   wb_t wb_q[$];
   logic [31:0] mem [logic [31:0]];
   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_5A5A;
   endfunction

   function automatic void push_tx(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                   input logic [31:0] wdata);
      tx_t t;
      t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
      tx_q.push_back(t);
   endfunction

   function automatic void push_wb(input logic [4:0] waddr, input logic [31:0] wdata);
      wb_t w;
      w.waddr = waddr; w.wdata = wdata;
      wb_q.push_back(w);
   endfunction

   // Reference model of the byte-lane arithmetic; returns 1 when the access splits.
   function automatic logic push_model(input logic [3:0] op, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [4:0] waddr);
      int sz, off;
      logic [7:0] m;
      logic [63:0] w, bf;
      logic [31:0] w0, w1, r;
      logic ld;
      sz  = (op == MEM_LB || op == MEM_LBU || op == MEM_SB) ? 1 :
            (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 2 : 4;
      off = int'(addr[1:0]);
      m   = 8'((1 << sz) - 1);
      m   = m << off;
      w   = {32'h0, data} << (8 * off);
      w0  = addr & 32'hFFFF_FFFC;
      w1  = w0 + 32'd4;
      ld  = (op >= MEM_LB) && (op <= MEM_LHU);
      push_tx(!ld, w0, m[3:0], w[31:0]);
      if (m[7:4] != 4'h0) push_tx(!ld, w1, m[7:4], w[63:32]);
      if (ld) begin
         bf = {mem_rd(w1), mem_rd(w0)} >> (8 * off);
         case (op)
            MEM_LB:  r = {{24{bf[7]}}, bf[7:0]};
            MEM_LBU: r = {24'h0, bf[7:0]};
            MEM_LH:  r = {{16{bf[15]}}, bf[15:0]};
            MEM_LHU: r = {16'h0, bf[15:0]};
            default: r = bf[31:0];
         endcase
         push_wb(waddr, r);
      end
      return m[7:4] != 4'h0;
   endfunction

   // Drives one op from IDLE to completion, acting as the bus slave and checking against the queues.
   task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] waddr, input int gd, input int rd, input int exp_stall);
      int cyc, gcnt, resp_at, stalls, wbs;
      logic [31:0] resp_addr;
      logic fin, held;
      tx_t ph, t;
      wb_t w;
      mem_op_i = op; mem_addr_i = addr; mem_data_i = data; reg_waddr_i = waddr;
      cyc = 0; gcnt = 0; resp_at = -1; stalls = 0; wbs = 0; fin = 1'b0; held = 1'b0;
      resp_addr = 32'h0;
      while (!fin) begin
         bus_rvalid_i = (cyc == resp_at);
         bus_rdata_i  = (cyc == resp_at) ? mem_rd(resp_addr) : 32'h0;
         bus_gnt_i    = bus_req_o && (gcnt >= gd);
         #1;
         if (held) begin
            checks++;
            if (!bus_req_o || bus_we_o !== ph.we || bus_addr_o !== ph.addr ||
                bus_be_o !== ph.be || bus_wdata_o !== ph.wdata) begin
               errors++;
               $display("FAIL hold_stable: got req=%b addr=%h be=%b wdata=%h, need req=1 addr=%h be=%b wdata=%h",
                        bus_req_o, bus_addr_o, bus_be_o, bus_wdata_o, ph.addr, ph.be, ph.wdata);
            end
         end
         held = 1'b0;
         if (bus_req_o) begin
            if (bus_gnt_i) begin
               checks++;
               if (tx_q.size() == 0) begin
                  errors++;
                  $display("FAIL bus_tx: unexpected transaction addr=%h be=%b", bus_addr_o, bus_be_o);
               end else begin
                  t = tx_q.pop_front();
                  if (bus_we_o !== t.we || bus_addr_o !== t.addr || bus_be_o !== t.be ||
                      (t.we && bus_wdata_o !== t.wdata)) begin
                     errors++;
                     $display("FAIL bus_tx: got we=%b addr=%h be=%b wdata=%h, need we=%b addr=%h be=%b wdata=%h",
                              bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, t.we, t.addr, t.be, t.wdata);
                  end
               end
               resp_at = cyc + 1 + rd; resp_addr = bus_addr_o; gcnt = 0;
            end else begin
               gcnt++; held = 1'b1;
               ph.we = bus_we_o; ph.addr = bus_addr_o; ph.be = bus_be_o; ph.wdata = bus_wdata_o;
            end
         end
         if (reg_we_o) begin
            wbs++;
            checks++;
            if (wb_q.size() == 0) begin
               errors++;
               $display("FAIL writeback: unexpected reg_we_o waddr=%0d wdata=%h", reg_waddr_o, reg_wdata_o);
            end else begin
               w = wb_q.pop_front();
               if (reg_waddr_o !== w.waddr || reg_wdata_o !== w.wdata) begin
                  errors++;
                  $display("FAIL writeback: got waddr=%0d wdata=%h, need waddr=%0d wdata=%h",
                           reg_waddr_o, reg_wdata_o, w.waddr, w.wdata);
               end
            end
         end
         if (stallreq_o) stalls++;
         else fin = 1'b1;
         cyc++;
         if (cyc > 300) begin
            errors++;
            $display("FAIL timeout: op %0d at %h not finished after %0d cycles", op, addr, cyc);
            fin = 1'b1;
         end
         @(posedge clk_i); @(negedge clk_i);
      end
      mem_op_i = MEM_NOP; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
      checks++;
      if (stalls != exp_stall) begin
         errors++;
         $display("FAIL stall_len: got %0d cycles, need %0d", stalls, exp_stall);
      end
      checks++;
      if (tx_q.size() != 0 || wb_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d transactions and %0d writebacks not seen", tx_q.size(), wb_q.size());
         tx_q.delete(); wb_q.delete();
      end
      checks++;
      if (wbs > 1) begin
         errors++;
         $display("FAIL we_pulses: got %0d, need at most 1", wbs);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || bus_addr_o !== 32'h0 || bus_be_o !== 4'h0 ||
          bus_wdata_o !== 32'h0 || reg_we_o !== 1'b0 || reg_waddr_o !== 5'd0 || reg_wdata_o !== 32'h0) begin
         errors++;
         $display("FAIL %s: got req=%b we=%b addr=%h be=%b wdata=%h rwe=%b rwa=%0d rwd=%h, need all zero",
                  name, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, reg_we_o, reg_waddr_o, reg_wdata_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
      check_reset_outputs("reset_values");
      mem_op_i = MEM_NOP; #1;
      checks++;
      if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall_nop: got %b, need 0", stallreq_o); end
      mem_op_i = MEM_SW; #1;
      checks++;
      if (stallreq_o !== 1'b1) begin errors++; $display("FAIL reset_stall_op: got %b, need 1", stallreq_o); end
      mem_op_i = MEM_NOP;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_nop();
      for (int c = 9; c <= 15; c++) begin
         mem_op_i = 4'(c); mem_addr_i = 32'h100;
         @(posedge clk_i); @(negedge clk_i);
         checks++;
         if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin
            errors++;
            $display("FAIL nop_code: op %0d gives stall=%b req=%b, need 0 0", c, stallreq_o, bus_req_o);
         end
      end
      mem_op_i = MEM_NOP;
   endtask

   task automatic test_sw();
      push_tx(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF);
      run_op(MEM_SW, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 3);
   endtask

   task automatic test_lb();
      mem[32'h200] = 32'h8012_3456;
      push_tx(1'b0, 32'h200, 4'b1000, 32'h0);
      push_wb(5'd5, 32'hFFFF_FF80);
      run_op(MEM_LB, 32'h203, 32'h0, 5'd5, 0, 0, 3);
      push_tx(1'b0, 32'h200, 4'b1000, 32'h0);
      push_wb(5'd6, 32'h0000_0080);
      run_op(MEM_LBU, 32'h203, 32'h0, 5'd6, 0, 0, 3);
   endtask

   task automatic test_split_lw();
      mem[32'h300] = 32'h3344_ABCD;
      mem[32'h304] = 32'h9988_1122;
      push_tx(1'b0, 32'h300, 4'b1100, 32'h0);
      push_tx(1'b0, 32'h304, 4'b0011, 32'h0);
      push_wb(5'd9, 32'h1122_3344);
      run_op(MEM_LW, 32'h302, 32'h0, 5'd9, 0, 0, 5);
   endtask

   task automatic test_split_sh();
      push_tx(1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hCD00_0000);
      push_tx(1'b1, 32'h0000_0000, 4'b0001, 32'h0000_00AB);
      run_op(MEM_SH, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd0, 0, 0, 5);
   endtask

   task automatic test_stall();
      mem[32'h400] = 32'hCAFE_F00D;
      push_tx(1'b0, 32'h400, 4'b1111, 32'h0);
      push_wb(5'd12, 32'hCAFE_F00D);
      run_op(MEM_LW, 32'h400, 32'h0, 5'd12, 5, 3, 11);
   endtask

   task automatic test_reset_wait1();
      logic [31:0] last_wd;
      last_wd = reg_wdata_o;
      mem_op_i = MEM_LW; mem_addr_i = 32'h302; reg_waddr_i = 5'd7;
      @(posedge clk_i); @(negedge clk_i);
      checks++;
      if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h300 || bus_be_o !== 4'b1100) begin
         errors++;
         $display("FAIL rst_req0: got req=%b addr=%h be=%b, need 1 00000300 1100", bus_req_o, bus_addr_o, bus_be_o);
      end
      bus_gnt_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = mem_rd(32'h300);
      @(posedge clk_i); @(negedge clk_i);
      bus_rvalid_i = 1'b0;
      checks++;
      if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h304 || bus_be_o !== 4'b0011) begin
         errors++;
         $display("FAIL rst_req1: got req=%b addr=%h be=%b, need 1 00000304 0011", bus_req_o, bus_addr_o, bus_be_o);
      end
      bus_gnt_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      bus_gnt_i = 1'b0; rst_i = 1'b1; mem_op_i = MEM_NOP;
      @(posedge clk_i); @(negedge clk_i);
      rst_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = mem_rd(32'h304);
      #1;
      check_reset_outputs("rst_wait1_values");
      checks++;
      if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_wait1_stall: got %b, need 0", stallreq_o); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i); @(negedge clk_i);
         bus_rvalid_i = 1'b0;
         checks++;
         if (reg_we_o !== 1'b0 || bus_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_wb: got reg_we=%b req=%b, need 0 0", reg_we_o, bus_req_o);
         end
      end
      mem[32'h500] = 32'h0BAD_CAFE;
      push_tx(1'b0, 32'h500, 4'b1111, 32'h0);
      push_wb(5'd3, 32'h0BAD_CAFE);
      run_op(MEM_LW, 32'h500, 32'h0, 5'd3, 0, 0, 3);
      if (last_wd == 32'hFFFF_FFFF) $display("note: previous writeback was all ones");
   endtask

   task automatic test_random();
      logic [3:0] op;
      logic [31:0] addr, data;
      logic sp;
      int gd, rd, ntx;
      for (int i = 0; i < 16; i++) begin
         op   = 4'($urandom_range(1, 8));
         addr = $urandom;
         data = $urandom;
         gd   = $urandom_range(0, 2);
         rd   = $urandom_range(0, 2);
         sp   = push_model(op, addr, data, 5'(i + 1));
         ntx  = sp ? 2 : 1;
         run_op(op, addr, data, 5'(i + 1), gd, rd, 1 + ntx * (gd + rd + 2));
      end
   endtask

   initial begin
      rst_i = 1'b1; mem_op_i = MEM_NOP; mem_addr_i = 32'h0; mem_data_i = 32'h0; reg_waddr_i = 5'd0;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
      test_reset();
      test_nop();
      test_sw();
      test_lb();
      test_split_lw();
      test_split_sh();
      test_stall();
      test_reset_wait1();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
